// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the register file
package regfile_pkg;
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: post-reset clear sequencer, readiness and dropped-write flag
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output logic              wr_ok,
    output logic              write_dropped
);
    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;
    logic              dropped_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= reg_write & ~ready_q;
            if (state_q == ST_CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
            end else begin
                ready_q <= 1'b1;
            end
        end
    end
    // The reset cycle itself must leave storage untouched.
    assign clr_we        = (state_q == ST_CLEAR) && !rst;
    assign clr_addr      = cnt_q;
    assign ready         = ready_q;
    assign wr_ok         = reg_write & ready_q & ~rst;
    assign write_dropped = dropped_q;
endmodule

// File: rtl/register_file_param.sv
// register_file_param: parametrised 2R1W register file with zero reg, bypass and hardware clear
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ZERO_REG       = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Ready,
    output logic              WriteDropped
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    regfile_clear_ctrl #(
        .ADDR_W(ADDR_W),
        .CLEAR_ON_RESET(CLEAR_ON_RESET != 0)
    ) u_ctrl (
        .clk(Clk),
        .rst(Rst),
        .reg_write(RegWrite),
        .clr_we(clr_we),
        .clr_addr(clr_addr),
        .ready(Ready),
        .wr_ok(wr_ok),
        .write_dropped(WriteDropped)
    );
    always_ff @(posedge Clk) begin
        if (clr_we)
            mem_q[clr_addr] <= '0;
        else if (wr_ok && !(ZERO_REG != 0 && WriteRegister == '0))
            mem_q[WriteRegister] <= WriteData;
    end
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return !Ready ? '0 :
               (ZERO_REG != 0 && a == '0) ? '0 :
               (BYPASS != 0 && RegWrite && WriteRegister == a) ? WriteData : mem_q[a];
    endfunction
    assign ReadData1 = rd(ReadRegister1);
    assign ReadData2 = rd(ReadRegister2);
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: scoreboard bench over three configurations against a behavioural model
module tb_register_file_param;
    typedef struct {
        int          k;
        bit          cr, c1, c2;
        bit          erdy, edrp;
        logic [31:0] e1, e2;
    } exp_t;
    logic        clk;
    logic        rst [3];
    logic        we  [3];
    logic [4:0]  wa  [3];
    logic [4:0]  ra1 [3];
    logic [4:0]  ra2 [3];
    logic [31:0] wd  [3];
    logic        rdy [3];
    logic        drp [3];
    logic [31:0] o0_rd1, o0_rd2, o1_rd1, o1_rd2;
    logic [15:0] o2_rd1, o2_rd2;
    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mm    [3][32];
    bit          known [3][32];
    int          edges [3];
    bit          m_ready [3];
    bit          m_drop  [3];

    register_file_param u_def (
        .Clk(clk), .Rst(rst[0]), .ReadRegister1(ra1[0]), .ReadRegister2(ra2[0]),
        .WriteRegister(wa[0]), .WriteData(wd[0]), .RegWrite(we[0]),
        .ReadData1(o0_rd1), .ReadData2(o0_rd2), .Ready(rdy[0]), .WriteDropped(drp[0])
    );
    register_file_param #(.BYPASS(0)) u_nobyp (
        .Clk(clk), .Rst(rst[1]), .ReadRegister1(ra1[1]), .ReadRegister2(ra2[1]),
        .WriteRegister(wa[1]), .WriteData(wd[1]), .RegWrite(we[1]),
        .ReadData1(o1_rd1), .ReadData2(o1_rd2), .Ready(rdy[1]), .WriteDropped(drp[1])
    );
    register_file_param #(.DATA_W(16), .ADDR_W(3), .CLEAR_ON_RESET(0)) u_small (
        .Clk(clk), .Rst(rst[2]), .ReadRegister1(ra1[2][2:0]), .ReadRegister2(ra2[2][2:0]),
        .WriteRegister(wa[2][2:0]), .WriteData(wd[2][15:0]), .RegWrite(we[2]),
        .ReadData1(o2_rd1), .ReadData2(o2_rd2), .Ready(rdy[2]), .WriteDropped(drp[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string nm, int k, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h", nm, k, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a1, a2;
        if (q.size() != 0) begin
            e  = q.pop_front();
            a1 = e.k == 0 ? o0_rd1 : e.k == 1 ? o1_rd1 : {16'h0, o2_rd1};
            a2 = e.k == 0 ? o0_rd2 : e.k == 1 ? o1_rd2 : {16'h0, o2_rd2};
            if (e.cr) begin
                check("ready", e.k, {31'h0, rdy[e.k]}, {31'h0, e.erdy});
                check("write_dropped", e.k, {31'h0, drp[e.k]}, {31'h0, e.edrp});
            end
            if (e.c1) check("read_data1", e.k, a1, e.e1);
            if (e.c2) check("read_data2", e.k, a2, e.e2);
        end
    end

    function automatic logic [31:0] mread(int k, int a, bit w, int wadr, logic [31:0] d, output bit ok);
        ok = 1'b1;
        if (!m_ready[k] || a == 0) return 32'h0;
        if (k != 1 && w && wadr == a) return d;
        ok = known[k][a];
        return mm[k][a];
    endfunction

    task automatic step(int k, bit r, bit w, int a, logic [31:0] d, int x1, int x2, bit chk = 1'b1);
        int          n = (k == 2) ? 8 : 32;
        logic [31:0] msk = (k == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        exp_t        e;
        bit          ok1, ok2;
        a  = a % n;
        x1 = x1 % n;
        x2 = x2 % n;
        d  = d & msk;
        rst[k] = r; we[k] = w; wa[k] = 5'(a); wd[k] = d; ra1[k] = 5'(x1); ra2[k] = 5'(x2);
        e.k    = k;
        e.cr   = chk;
        e.erdy = m_ready[k];
        e.edrp = m_drop[k];
        e.e1   = mread(k, x1, w, a, d, ok1);
        e.e2   = mread(k, x2, w, a, d, ok2);
        e.c1   = ok1 & chk;
        e.c2   = ok2 & chk;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_ready[k] = 1'b0;
            m_drop[k]  = 1'b0;
            edges[k]   = 0;
        end else begin
            m_drop[k] = w & !m_ready[k];
            if (m_ready[k]) begin
                if (w && a != 0) begin
                    mm[k][a]    = d;
                    known[k][a] = 1'b1;
                end
            end else begin
                edges[k]++;
                if (edges[k] == ((k == 2) ? 1 : n)) begin
                    m_ready[k] = 1'b1;
                    if (k != 2)
                        for (int i = 0; i < n; i++) begin
                            mm[k][i]    = 32'h0;
                            known[k][i] = 1'b1;
                        end
                end
            end
        end
        #1;
    endtask

    task automatic rnd_read(int k);
        step(k, 0, 0, 0, 0, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
    endtask

    task automatic run(int k);
        step(k, 1, 0, 0, 0, 0, 0, 0);
        step(k, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            if (i == 3) step(k, 0, 1, 5, 32'hDEAD_BEEF, 5, 0);
            else rnd_read(k);
        for (int i = 0; i < 32; i++) step(k, 0, 0, 0, 0, i, 31 - i);
        step(k, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) rnd_read(k);
        step(k, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) rnd_read(k);
        for (int i = 8; i <= 25; i++) step(k, 0, 1, i, 32'hA5A5_0000 + 32'(i), i - 1, i);
        for (int i = 8; i <= 25; i++) step(k, 0, 0, 0, 0, i, i + 1);
        step(k, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        step(k, 0, 0, 0, 0, 0, 0);
        step(k, 0, 1, 9, 32'h1234_5678, 9, 9);
        step(k, 0, 0, 0, 0, 9, 1);
        step(k, 0, 1, 7, 32'hBEEF, 7, 3);
        step(k, 0, 0, 0, 0, 7, 7);
        for (int i = 0; i < 300; i++)
            step(k, 0, bit'($urandom_range(1, 0)), int'($urandom_range(31, 0)), $urandom,
                 int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
        step(k, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) rnd_read(k);
        rst[k] = 1'b1;
        we[k]  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; we[k] = 1'b0; wa[k] = '0; wd[k] = '0; ra1[k] = '0; ra2[k] = '0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) run(k);
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 0, 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised successor to the pipeline's 32×32 register file: configurable data width and depth, optional hardwired zero register, optional same-cycle write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset and signals readiness. It sits in the ID stage and is written from WB. Reads are combinational and writes are on the rising clock edge, so existing ID/WB timing is unchanged.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (derived, not overridable)
- ZERO_REG, 1, when 1: register 0 always reads 0 and writes to it are discarded
- BYPASS, 1, when 1: a read that matches the current valid write returns WriteData in the same cycle
- CLEAR_ON_RESET, 1, when 1: run the clear sequence after reset; when 0: contents are left undefined
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-high
- ReadRegister1  in  ADDR_W  read port 1 address
- ReadRegister2  in  ADDR_W  read port 2 address
- WriteRegister  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- RegWrite  in  1  write enable
- ReadData1  out  DATA_W  read port 1 data (combinational)
- ReadData2  out  DATA_W  read port 2 data (combinational)
- Ready  out  1  high once the block accepts writes; registered
- WriteDropped  out  1  one-cycle pulse: a RegWrite was ignored because Ready was low; registered

## Operation
- States:
  - ST_CLEAR: sequencer writes 0 to entry cnt and increments cnt each cycle.
  - ST_RUN: normal operation.
- Rst=1 at a clock edge:
  - state <= ST_CLEAR if CLEAR_ON_RESET, else ST_RUN.
  - cnt <= 0, Ready <= 0, WriteDropped <= 0.
  - Register contents are not touched in the reset cycle itself.
- ST_CLEAR (Rst=0):
  - Each edge: mem[cnt] <= 0, cnt <= cnt+1.
  - When cnt == NUM_REGS-1: state <= ST_RUN, Ready <= 1.
  - cnt is ADDR_W bits wide and wraps to 0 on that final edge.
- ST_RUN:
  - The write is performed when RegWrite=1, unless ZERO_REG=1 and WriteRegister=0.
  - Ready stays 1 until the next Rst.
- CLEAR_ON_RESET=0: Ready <= 1 on the first edge with Rst=0.
- Writes while Ready=0 (reset or clear in progress): discarded; WriteDropped <= 1 on that edge, otherwise WriteDropped <= 0.
- Read data, per port, in priority order:
  - Ready=0 → 0.
  - ZERO_REG and address=0 → 0.
  - BYPASS and RegWrite and WriteRegister==address → WriteData.
  - Otherwise mem[address].
- Both read ports may address the same register, or the write address, simultaneously; each port resolves independently.

## Timing
- Write latency: data is visible at the read port the cycle after the write edge. With BYPASS=1 it is also visible in the write cycle itself.
- Clear duration: Ready rises on the NUM_REGS-th edge after the first edge with Rst=0 (32 edges at default).
- Rst asserted mid-clear: sequencer restarts with cnt=0 on the next edge. Already-cleared entries stay 0; the full sequence reruns.
- Rst asserted in ST_RUN: Ready drops on that edge and the read ports return 0 immediately after it.
- Reset values: Ready=0, WriteDropped=0, cnt=0; ReadData1/2 read 0 while Ready=0.
- No combinational path from Rst to outputs; ReadData depends on addresses, Ready, mem, and (when BYPASS=1) on WriteData/WriteRegister/RegWrite.

## Structure
- Shared package regfile_pkg holds:
  - state encodings ST_CLEAR and ST_RUN;
  - the default DATA_W/ADDR_W constants, reused by ID/WB stage instantiations.
- Sub-module regfile_clear_ctrl (FSM, cnt, Ready, WriteDropped) outputs:
  - clr_we
  - clr_addr
  - Ready
  - wr_ok (RegWrite qualified by Ready)
- The top level holds the storage array, the write mux (clear vs. normal) and the read muxes.

## Test plan
- Reset then idle, defaults: Rst=1 for 2 edges, then low → Ready=0 for 31 edges, Ready=1 on the 32nd; afterwards reading registers 0..31 returns 0x00000000.
- Write/read sweep: after Ready, write reg i = 0xA5A50000+i for i=8..25, then read pairs (i, i+1) → each port returns its value; register 0 reads 0 after writing 0xFFFFFFFF to it (ZERO_REG=1).
- Bypass: in one cycle, RegWrite=1, WriteRegister=9, WriteData=0x12345678, ReadRegister1=9 → ReadData1=0x12345678 in that cycle with BYPASS=1. With BYPASS=0 the old value is returned that cycle and the new value on the next.
- Dropped write: RegWrite=1 with WriteRegister=5, 0xDEADBEEF during clear → WriteDropped pulses for 1 cycle; after Ready, reg 5 reads 0.
- Reset mid-clear: assert Rst 10 edges into the clear → Ready stays 0 and rises 32 edges after Rst deasserts again; all registers read 0.
- Parameter variant DATA_W=16, ADDR_W=3, CLEAR_ON_RESET=0 → Ready=1 one edge after reset; write reg 7 = 0xBEEF and read back 0xBEEF; cnt wrap is not exercised.
